// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding, bubble encoding, datapath
// width, and the IF/ID pipeline record consumed by the decode stage.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  // Encoding written into IF/ID when no real instruction is delivered.
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instruction;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_plus4;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory address/data, pipeline control inputs
// (stall, flush, redirects, halt) and the IF/ID outputs plus status.
//   master : the fetch unit (drives InstAddress, IF/ID and status)
//   slave  : the surrounding pipeline / instruction memory
interface fetch_unit_if;
  import cpu_pkg::*;

  logic [WORD_W-1:0] InstAddress;
  logic [WORD_W-1:0] Instruction;
  logic              Stall;
  logic              Flush;
  logic              BranchTaken;
  logic [WORD_W-1:0] BranchTarget;
  logic              Jump;
  logic [WORD_W-1:0] JumpTarget;
  logic              Halt;
  logic [WORD_W-1:0] IfIdInstruction;
  logic [WORD_W-1:0] IfIdPC;
  logic [WORD_W-1:0] IfIdPCPlus4;
  logic              IfIdValid;
  logic              Halted;
  logic              AddrError;
  logic [WORD_W-1:0] FetchCount;

  modport master (
    input  Instruction, Stall, Flush, BranchTaken, BranchTarget,
           Jump, JumpTarget, Halt,
    output InstAddress, IfIdInstruction, IfIdPC, IfIdPCPlus4, IfIdValid,
           Halted, AddrError, FetchCount
  );

  modport slave (
    output Instruction, Stall, Flush, BranchTaken, BranchTarget,
           Jump, JumpTarget, Halt,
    input  InstAddress, IfIdInstruction, IfIdPC, IfIdPCPlus4, IfIdValid,
           Halted, AddrError, FetchCount
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
//   clk, rst_n  : clock, async active-low reset
//   load        : capture instruction/pc, set valid
//   bubble      : write NOP, clear valid, keep pc fields
//   instruction : word fetched at pc
//   pc          : fetch address
//   q           : registered IF/ID record
// With neither load nor bubble the register holds.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [WORD_W-1:0] instruction,
  input  logic [WORD_W-1:0] pc,
  output if_id_t            q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.instruction <= NOP_WORD;
      q.pc          <= '0;
      q.pc_plus4    <= '0;
      q.valid       <= 1'b0;
    end else if (load) begin
      q.instruction <= instruction;
      q.pc          <= pc;
      q.pc_plus4    <= pc + WORD_W'(4);
      q.valid       <= 1'b1;
    end else if (bubble) begin
      q.instruction <= NOP_WORD;
      q.valid       <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, addresses the combinational
// instruction memory and registers the returned word into IF/ID.
//   Clk, Rst_n : clock, async active-low reset
//   bus        : fetch_unit_if.master (memory port, control, IF/ID, status)
// Per-edge priority in S_RUN: halt, redirect (branch over jump),
// out-of-range fetch, stall, flush, normal fetch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned       IMEM_WORDS = 512,
  parameter logic [WORD_W-1:0] NOP_WORD   = cpu_pkg::NOP_WORD
) (
  input  logic                Clk,
  input  logic                Rst_n,
  fetch_unit_if.master        bus
);

  // 33 bits so the byte limit never truncates for large memories.
  localparam logic [WORD_W:0] PC_LIMIT = (WORD_W+1)'(IMEM_WORDS) * (WORD_W+1)'(4);

  fetch_state_t      st, st_nx;
  logic [WORD_W-1:0] pc, pc_nx, pc_plus4;
  logic [WORD_W-1:0] fetch_count;
  logic              addr_error;
  logic              load, bubble, err_set, out_of_range;
  if_id_t            if_id;

  assign pc_plus4     = pc + WORD_W'(4);
  assign out_of_range = ({1'b0, pc} >= PC_LIMIT);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st          <= S_BOOT;
      pc          <= RESET_PC;
      fetch_count <= '0;
      addr_error  <= 1'b0;
    end else begin
      st <= st_nx;
      pc <= pc_nx;
      if (load)    fetch_count <= fetch_count + WORD_W'(1);
      if (err_set) addr_error  <= 1'b1;
    end
  end

  always_comb begin
    st_nx   = st;
    pc_nx   = pc;
    load    = 1'b0;
    bubble  = 1'b0;
    err_set = 1'b0;
    unique case (st)
      S_BOOT: begin
        st_nx  = S_RUN;
        bubble = 1'b1;
      end
      S_RUN: begin
        if (bus.Halt) begin
          st_nx  = S_HALT;
          bubble = 1'b1;
        end else if (bus.BranchTaken) begin
          pc_nx  = bus.BranchTarget & ~WORD_W'(3);
          bubble = 1'b1;
        end else if (bus.Jump) begin
          pc_nx  = bus.JumpTarget & ~WORD_W'(3);
          bubble = 1'b1;
        end else if (out_of_range) begin
          err_set = 1'b1;
          st_nx   = S_HALT;
          bubble  = 1'b1;
        end else if (bus.Stall) begin
          // hold PC and IF/ID
        end else if (bus.Flush) begin
          pc_nx  = pc_plus4;
          bubble = 1'b1;
        end else begin
          pc_nx = pc_plus4;
          load  = 1'b1;
        end
      end
      S_HALT: begin
        bubble = 1'b1;
      end
      default: begin
        st_nx  = S_HALT;
        bubble = 1'b1;
      end
    endcase
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .load        (load),
    .bubble      (bubble),
    .instruction (bus.Instruction),
    .pc          (pc),
    .q           (if_id)
  );

  assign bus.InstAddress     = pc;
  assign bus.IfIdInstruction = if_id.instruction;
  assign bus.IfIdPC          = if_id.pc;
  assign bus.IfIdPCPlus4     = if_id.pc_plus4;
  assign bus.IfIdValid       = if_id.valid;
  assign bus.Halted          = (st == S_HALT);
  assign bus.AddrError       = addr_error;
  assign bus.FetchCount      = fetch_count;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory address; the memory returns its word combinationally the same cycle.
- Registers that word with its PC into the IF/ID pipeline register for the decoder.
- Handles stall, flush, branch/jump redirect, out-of-range fetch detection and halt.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- IMEM_WORDS, 512, instruction memory depth in 32-bit words; legal fetch bytes are 0 .. IMEM_WORDS*4-1.
- NOP_WORD, 32'h0000_0000, encoding inserted into IF/ID for bubbles.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- InstAddress  output  32  byte address to instruction memory; always equals PC.
- Instruction  input  32  word returned by instruction memory for InstAddress, same cycle.
- Stall  input  1  hazard stall: hold PC and IF/ID.
- Flush  input  1  squash IF/ID contents (bubble) this cycle.
- BranchTaken  input  1  branch resolved taken.
- BranchTarget  input  32  branch target byte address.
- Jump  input  1  jump redirect.
- JumpTarget  input  32  jump target byte address.
- Halt  input  1  stop fetching permanently (until reset).
- IfIdInstruction  output  32  registered instruction.
- IfIdPC  output  32  registered PC of that instruction.
- IfIdPCPlus4  output  32  registered PC+4.
- IfIdValid  output  1  IF/ID holds a real instruction.
- Halted  output  1  fetch is in S_HALT.
- AddrError  output  1  sticky: fetch attempted at PC >= IMEM_WORDS*4.
- FetchCount  output  32  count of instructions delivered (IfIdValid loads); wraps modulo 2^32.

Behaviour:
- Reset (async, Rst_n=0): PC=RESET_PC, IfIdInstruction=NOP_WORD, IfIdPC=0, IfIdPCPlus4=0, IfIdValid=0, Halted=0, AddrError=0, FetchCount=0, state=S_BOOT. Mid-operation reset aborts everything immediately.
- State machine, 2-bit:
  - S_BOOT: one cycle after reset release; PC held, IF/ID stays bubble; next state S_RUN unconditionally.
  - S_RUN: normal fetch.
  - S_HALT: PC frozen, IF/ID = bubble, all redirect/stall inputs ignored; exit only via reset.
- S_RUN per-edge priority, highest first:
  1. Halt=1: go to S_HALT; IF/ID <= bubble.
  2. Redirect: BranchTaken wins over Jump (the branch is the older instruction). PC <= target & ~32'h3, so low 2 bits are forced to zero. IF/ID <= bubble regardless of Stall/Flush.
  3. PC out of range (PC >= IMEM_WORDS*4): AddrError <= 1, go to S_HALT, IF/ID <= bubble.
  4. Stall=1: PC and all IF/ID outputs hold. Stall has priority over Flush; FetchCount holds.
  5. Flush=1: PC <= PC+4, IF/ID <= bubble.
  6. Otherwise: PC <= PC+4; IfIdInstruction <= Instruction, IfIdPC <= PC, IfIdPCPlus4 <= PC+4, IfIdValid <= 1, FetchCount++.
- Bubble means IfIdInstruction=NOP_WORD, IfIdValid=0; IfIdPC and IfIdPCPlus4 hold their previous values.
- Latency: an instruction at address A appears in IF/ID one edge after PC=A with no stall.
- Sequential fetch is one instruction per cycle.
- Redirect costs one bubble: the target is fetched in the cycle after the redirect edge.
- PC+4 wraps modulo 2^32. Wrap-around into range is never reached, because out-of-range detection halts first.
- Halted = (state == S_HALT), registered. AddrError stays set until reset.
- Instruction is sampled only in rule 6. X or undefined data from out-of-range addresses never reaches IF/ID.

Decomposition:
- Shared package cpu_pkg holds:
  - fetch state enum: S_BOOT, S_RUN, S_HALT;
  - NOP_WORD constant;
  - WORD_W = 32;
  - the IF/ID struct type (instruction, pc, pc_plus4, valid), reused by the decode stage.
- One natural sub-module, if_id_reg: the IF/ID pipeline register with load/hold/bubble controls.
- PC logic and the FSM stay in fetch_unit.

Test Plan:
- Reset release with RESET_PC=0 and memory words 0x11,0x22,0x33 at words 0..2 -> S_BOOT cycle with IfIdValid=0, then IF/ID shows (0x11, PC 0), (0x22, PC 4), (0x33, PC 8) on consecutive edges; FetchCount=3.
- Stall held 2 cycles while IF/ID holds PC 4 -> PC stays 8, IF/ID stays (0x22, 4); releasing Stall continues with (0x33, 8). Stall plus Flush together also hold.
- BranchTaken=1 with BranchTarget=0x42 and Jump=1 with JumpTarget=0x100 on the same edge -> PC=0x40, IfIdValid=0 for one cycle, then IF/ID shows PC 0x40.
- PC stepping to 0x7FC then 0x800 with IMEM_WORDS=512 -> word at 0x7FC delivered; at PC 0x800 AddrError=1, Halted=1, IfIdValid=0; later BranchTaken is ignored.
- Halt pulse in S_RUN -> Halted=1 next edge and PC frozen; Rst_n low mid-run -> all outputs at reset values immediately, without waiting for a clock edge.
- Flush=1 for one cycle at PC 8 -> IfIdValid=0, PC advances to 0xC, and FetchCount does not increment.
